column_pingpong_buffer: RTL

//  Two-bank column buffer between frame_manager (producer) and hub75_output (consumer).

---
 rtl/display_pkg.sv | 23 ++
 rtl/colbuf_bank.sv | 53 +++++
 rtl/column_pingpong_buffer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared display types and default geometry for the HUB75 column path.
package display_pkg;

    localparam int NUM_ROWS_DEFAULT  = 64;
    localparam int RGB_RES_DEFAULT   = 9;
    localparam int SCAN_RATE_DEFAULT = 32;
    localparam int COL_ADDR_W        = $clog2(SCAN_RATE_DEFAULT);
    localparam int SHOW_CNT_W        = 4;

    typedef logic [1:0][NUM_ROWS_DEFAULT-1:0][RGB_RES_DEFAULT-1:0] column_pair_t;
    typedef logic [COL_ADDR_W-1:0] col_addr_t;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        SHOWING
    } bank_state_e;

    function automatic logic [SHOW_CNT_W-1:0] sat_inc(input logic [SHOW_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/colbuf_bank.sv
// One ping-pong bank: column pair storage, scan address, occupancy state and show counter.
module colbuf_bank
    import display_pkg::*;
#(
    parameter int DATA_W = 2 * NUM_ROWS_DEFAULT * RGB_RES_DEFAULT,
    parameter int ADDR_W = COL_ADDR_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic                  show_en,
    input  logic                  release_en,
    input  logic                  beat,
    output bank_state_e           state,
    output logic [SHOW_CNT_W-1:0] show_cnt,
    output logic [DATA_W-1:0]     data,
    output logic [ADDR_W-1:0]     addr
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= EMPTY;
            show_cnt <= '0;
        end else begin
            case (state)
                EMPTY:   if (wr_en) state <= FULL;
                FULL: begin
                    if (show_en) begin
                        state    <= SHOWING;
                        show_cnt <= '0;
                    end
                end
                SHOWING: begin
                    if (release_en) state <= EMPTY;
                    else if (beat)  show_cnt <= sat_inc(show_cnt);
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // NOTE: the payload is not reset; the bank state alone decides whether it is meaningful.
    always_ff @(posedge clk_in) begin
        if (wr_en && state == EMPTY) begin
            data <= wr_data;
            addr <= wr_addr;
        end
    end

endmodule

// File: rtl/column_pingpong_buffer.sv
// Two-bank column pair buffer between frame_manager and hub75_output.
// Optional statistics counters are built when COLBUF_STATS_EN is defined.
module column_pingpong_buffer
    import display_pkg::*;
#(
    parameter int NUM_ROWS    = NUM_ROWS_DEFAULT,
    parameter int RGB_RES     = RGB_RES_DEFAULT,
    parameter int SCAN_RATE   = SCAN_RATE_DEFAULT,
    parameter int MIN_SHOWS   = 1,
    parameter int REPEAT_LAST = 1,
    localparam int DATA_W     = 2 * NUM_ROWS * RGB_RES,
    localparam int ADDR_W     = $clog2(SCAN_RATE)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_columns,
    input  logic [ADDR_W-1:0] s_col_num,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_columns,
    output logic [ADDR_W-1:0] m_col_num
`ifdef COLBUF_STATS_EN
    ,
    output logic [15:0]       repeat_count,
    output logic [15:0]       underrun_count
`endif
);

    localparam logic [SHOW_CNT_W-1:0] MIN_SHOWS_C = SHOW_CNT_W'(MIN_SHOWS);

    bank_state_e           st       [2];
    logic [SHOW_CNT_W-1:0] cnt      [2];
    logic [DATA_W-1:0]     bank_dat [2];
    logic [ADDR_W-1:0]     bank_adr [2];

    logic [1:0] wr_en, show_en, release_en, beat;
    logic       any_show, cur, other_full, hs, done, swap, drop;
    logic       s_ready_nxt, m_valid_nxt, load_idx;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        wr_en       = '0;
        show_en     = '0;
        release_en  = '0;
        beat        = '0;
        s_ready_nxt = 1'b0;

        any_show   = (st[0] == SHOWING) || (st[1] == SHOWING);
        cur        = (st[1] == SHOWING);
        other_full = (st[~cur] == FULL);
        hs         = m_valid && m_ready && any_show;
        done       = hs && (sat_inc(cnt[cur]) >= MIN_SHOWS_C);
        swap       = done && other_full;
        drop       = done && !other_full && (REPEAT_LAST == 0);

        // Writes always target the lowest bank that was EMPTY at this edge.
        if (s_valid && s_ready) begin
            if (st[0] == EMPTY) wr_en[0] = 1'b1;
            else                wr_en[1] = 1'b1;
        end

        for (int i = 0; i < 2; i++) begin
            beat[i]       = hs && (cur == 1'(i));
            release_en[i] = (swap || drop) && (cur == 1'(i));
            show_en[i]    = (swap && (cur != 1'(i))) || (!any_show && st[i] == FULL);
            if ((st[i] == EMPTY && !wr_en[i]) || release_en[i]) s_ready_nxt = 1'b1;
        end

        m_valid_nxt = (any_show && !drop) || (|show_en);
        load_idx    = show_en[1];
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        colbuf_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .wr_en      (wr_en[g]),
            .wr_data    (s_columns),
            .wr_addr    (s_col_num),
            .show_en    (show_en[g]),
            .release_en (release_en[g]),
            .beat       (beat[g]),
            .state      (st[g]),
            .show_cnt   (cnt[g]),
            .data       (bank_dat[g]),
            .addr       (bank_adr[g])
        );
    end

    // Output registers reload only when a bank becomes SHOWING; repeats hold the same pair.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            m_columns <= '0;
            m_col_num <= '0;
        end else begin
            s_ready <= s_ready_nxt;
            m_valid <= m_valid_nxt;
            if (|show_en) begin
                m_columns <= bank_dat[load_idx];
                m_col_num <= bank_adr[load_idx];
            end
        end
    end

`ifdef COLBUF_STATS_EN
    // A repeat is any handshake of a pair that has already been handshaken once.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            repeat_count   <= '0;
            underrun_count <= '0;
        end else begin
            if (hs && cnt[cur] != '0 && repeat_count != 16'hFFFF)
                repeat_count <= repeat_count + 16'd1;
            if (m_ready && !m_valid && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule
